// File: rtl/bus_arb_rr.sv
// Round-robin bus arbiter: active-low requests in, one-hot active-low grant out, parks on DEFAULT_OWNER when idle.
// Optional hold limit forcing rotation is compiled in with `define BUS_ARB_HOLD_LIMIT_EN.
module bus_arb_rr #(
  parameter int NUM_MASTERS   = 4,
  parameter int DEFAULT_OWNER = 0,
  parameter int MAX_HOLD      = 16,
  localparam int OW           = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] req_,
  output logic [NUM_MASTERS-1:0] grnt_,
  output logic [OW-1:0]          owner,
  output logic                   busy
);

  localparam logic [OW-1:0]          DEF_OWNER = OW'(DEFAULT_OWNER);
  localparam logic [NUM_MASTERS-1:0] RST_GRNT  = ~(NUM_MASTERS'(1) << DEFAULT_OWNER);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 16) begin : g_bad_num
    $error("bus_arb_rr: NUM_MASTERS out of range 2..16");
  end
  if (DEFAULT_OWNER < 0 || DEFAULT_OWNER >= NUM_MASTERS) begin : g_bad_def
    $error("bus_arb_rr: DEFAULT_OWNER must be below NUM_MASTERS");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("bus_arb_rr: MAX_HOLD out of range 2..255");
  end

  typedef enum logic {PARK = 1'b0, OWN = 1'b1} state_e;

  state_e                   state_q, state_d;
  logic [OW-1:0]            owner_q, owner_d;
  logic [OW-1:0]            rr_q, rr_d;
  logic [NUM_MASTERS-1:0]   grnt_q, grnt_d;
  logic                     busy_q, busy_d;
  logic [NUM_MASTERS-1:0]   req;
  logic [OW:0]              park_pick;
  logic [OW:0]              hand_pick;
  logic                     force_hand;
`ifdef BUS_ARB_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0]             hold_q, hold_d;
  logic [NUM_MASTERS-1:0] own_mask;
  logic                   others;
`endif

  assign req = ~req_;

  // Returns {found, index}: nearest set bit at circular distance 1..N from base
  // (distance N, i.e. base itself, only when incl_base). Descending scan so the
  // closest hit is written last.
  function automatic logic [OW:0] rr_search(input logic [NUM_MASTERS-1:0] r,
                                            input logic [OW-1:0]          base,
                                            input logic                   incl_base);
    logic [OW:0]   res;
    logic [OW-1:0] idx_l;
    int            idx;
    res = '0;
    for (int d = NUM_MASTERS; d >= 1; d--) begin
      idx   = (int'(base) + d) % NUM_MASTERS;
      idx_l = idx[OW-1:0];
      if (r[idx_l] && (incl_base || d != NUM_MASTERS)) res = {1'b1, idx_l};
    end
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= PARK;
      owner_q <= DEF_OWNER;
      rr_q    <= DEF_OWNER;
      grnt_q  <= RST_GRNT;
      busy_q  <= 1'b0;
`ifdef BUS_ARB_HOLD_LIMIT_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      grnt_q  <= grnt_d;
      busy_q  <= busy_d;
`ifdef BUS_ARB_HOLD_LIMIT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    park_pick = rr_search(req, rr_q, 1'b1);
    hand_pick = rr_search(req, owner_q, 1'b0);
`ifdef BUS_ARB_HOLD_LIMIT_EN
    hold_d            = hold_q;
    own_mask          = '0;
    own_mask[owner_q] = 1'b1;
    others            = |(req & ~own_mask);
    force_hand        = req[owner_q] && others && (hold_q == HOLD_LAST);
`else
    force_hand        = 1'b0;
`endif
    case (state_q)
      PARK: begin
        if (park_pick[OW]) begin
          state_d = OWN;
          owner_d = park_pick[OW-1:0];
          rr_d    = park_pick[OW-1:0];
        end
      end
      OWN: begin
        if (!req[owner_q] || force_hand) begin
          if (hand_pick[OW]) begin
            owner_d = hand_pick[OW-1:0];
            rr_d    = hand_pick[OW-1:0];
          end else begin
            state_d = PARK;
            owner_d = DEF_OWNER;
          end
`ifdef BUS_ARB_HOLD_LIMIT_EN
          hold_d = '0;
        end else if (others) begin
          hold_d = hold_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d = PARK;
        owner_d = DEF_OWNER;
      end
    endcase
  end

  // Outputs are precomputed from next state so they leave a flop.
  always_comb begin
    grnt_d          = '1;
    grnt_d[owner_d] = 1'b0;
    busy_d          = (state_d == OWN);
  end

  assign grnt_ = grnt_q;
  assign owner = owner_q;
  assign busy  = busy_q;

endmodule

// File: doc/bus_arb_rr.md
# bus_arb_rr

Parametrised round-robin bus arbiter for the system bus, replacing the fixed two-requester arbiter. It accepts NUM_MASTERS active-low requests and drives one-hot active-low grants. When no master is requesting, the grant parks on a default owner. An optional hold limit forces rotation so that no master can monopolise the bus.

## Interface
- NUM_MASTERS, 4: number of requesting masters; legal range 2..16.
- DEFAULT_OWNER, 0: master index that receives the parked grant when nobody requests; must be < NUM_MASTERS.
- MAX_HOLD, 16: cycles an owner may keep the bus while another master waits; legal range 2..255; used only with BUS_ARB_HOLD_LIMIT_EN.
- OW, $clog2(NUM_MASTERS): owner index width (localparam).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- req_  in  NUM_MASTERS  bus requests, active-low, bit i = master i.
- grnt_  out  NUM_MASTERS  bus grants, active-low, always exactly one bit low.
- owner  out  OW  index of the master whose grant bit is low.
- busy  out  1  high when the current owner is actively requesting.

## Operation
- All outputs are registered. Reset values: grnt_ = all ones except bit DEFAULT_OWNER = 0; owner = DEFAULT_OWNER; busy = 0; rr pointer = DEFAULT_OWNER; hold counter = 0.
- The state machine has two states.
  - PARK: the grant sits on owner with no active request. If any req_ bit is low, grant the first requester found by circular search starting at index (rr pointer + 1). Go to OWN and set rr pointer to the new owner. The parked owner is a valid winner if it comes up in the search. If no req_ bit is low, stay in PARK.
  - OWN: the owner keeps the grant while req_[owner] = 0.
    - When req_[owner] = 1, hand off on the same edge to the next requester in circular order after the owner; stay in OWN.
    - If there is no other requester, return the grant to DEFAULT_OWNER and go to PARK.
- No dead cycle on handoff: the old grant deasserts and the new grant asserts on the same edge.
- Only the owner's bit of req_ can keep a grant. Requests from other masters are held off until the owner releases, or until the hold limit fires.
- busy = 1 exactly while the state is OWN.
- A request that drops before it is granted is forgotten; the arbiter keeps no request history.

## Timing
- Request-to-grant latency: req_ is sampled at edge N and grnt_ changes after edge N. The minimum latency is 1 cycle.
- Release-to-handoff: req_[owner] = 1 is sampled at edge N, and the next grant is visible after edge N.
- Simultaneous requests: the winner is the lowest circular distance from (rr pointer + 1), wrapping from NUM_MASTERS-1 to 0.
- An owner that releases and re-requests in the same cycle is treated as released.
- Reset mid-operation: at the next edge with rst = 0, all state returns to the reset values regardless of requests.

## Configuration
- BUS_ARB_HOLD_LIMIT_EN defined:
  - An 8-bit hold counter clears on every ownership change and increments each cycle in OWN while some other req_ bit is low.
  - When the counter reaches MAX_HOLD-1 while another request is pending, the next edge forces a handoff to the next circular requester even though req_[owner] is still 0.
  - The displaced master re-enters arbitration as a normal requester.
- BUS_ARB_HOLD_LIMIT_EN undefined: no counter is built, and the owner holds the bus indefinitely.

## Test plan
All scenarios use NUM_MASTERS=4, DEFAULT_OWNER=0, MAX_HOLD=8.
- Reset with no requests: hold rst = 0 for 2 cycles, then release. Required: grnt_ = 4'b1110, owner = 0, busy = 0, and outputs stay there for 10 cycles.
- Single request: drive req_[1] = 0. Required: 1 cycle later grnt_ = 4'b1101, busy = 1. Release req_[1]. Required: 1 cycle later grnt_ = 4'b1110, busy = 0.
- Round-robin fairness: hold req_ = 4'b0000 and have each owner release for 1 cycle after 3 cycles of ownership. Required grant order: 1, 2, 3, 0, 1, with no cycle where zero or two grants are low.
- Back-to-back handoff: master 2 owns the bus and master 3 is requesting. Master 2 releases. Required: grnt_ goes 4'b1011 to 4'b0111 on one edge, with busy staying 1.
- Hold limit (macro defined): master 1 holds req_ low, and master 3 requests from cycle 0. Required: forced handoff to master 3 after exactly 8 cycles of master 1 ownership. With the macro undefined, master 1 keeps the bus for 100 cycles.
- Reset mid-ownership: master 3 owns the bus and rst drops for 1 cycle. Required: at the next edge grnt_ = 4'b1110, owner = 0, busy = 0, even though req_[3] = 0. Master 3 is then re-granted 1 cycle after rst rises.
